debounce_sync: RTL and testbench

Input-conditioning stage that sits directly upstream of the edge detector. It takes an asynchronous, bouncy level such as a pushbutton or external strap, and synchronises it into clk. It qualifies each level change by requiring STABLE_CYCLES consecutive matching samples, then drives a clean level, db_out, into the edge detector's d_in. It also counts rejected bounces for debug.

---
 rtl/debounce_pkg.sv | 24 ++
 rtl/sync_ff_chain.sv | 32 +++
 rtl/debounce_sync.sv | 131 +++++++++++++
 tb/tb_debounce_sync.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg
// Shared types and helpers for the debounce_sync input-conditioning block.
//   db_state_t : qualifier FSM state, 2-bit encoding
//   cntWidth() : width of the qualify counter for a given stable-run length
package debounce_pkg;

    // Two settled levels plus one "checking" state for each direction of change.
    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        CHK_HI    = 2'b01,
        STABLE_HI = 2'b10,
        CHK_LO    = 2'b11
    } db_state_t;

    // The counter only has to reach stableCycles-1, so $clog2 of the run length
    // is exactly enough; clamp to one bit so tiny run lengths still elaborate.
    function automatic int cntWidth(input int stableCycles);
        if (stableCycles <= 2) begin
            return 1;
        end
        return $clog2(stableCycles);
    endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// sync_ff_chain
// Plain multi-flop synchroniser for a single asynchronous bit. It lives in its
// own module so that clock-domain-crossing waivers attach to one place.
// Ports:
//   clk   : destination clock
//   reset : asynchronous active-high reset, clears every stage to 0
//   d     : asynchronous input bit
//   q     : synchronised output (last stage)
module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_q;

    // Shift the raw bit through the chain; stage 0 is the metastability catcher
    // and only the final stage is allowed to leave this module.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d};
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// debounce_sync
// Synchronises a bouncy asynchronous level into clk and only passes a level
// change once STABLE_CYCLES consecutive synchronised samples agree. Aborted
// candidate changes are counted in a saturating debug counter.
// Reset release is expected to arrive already synchronised to clk.
// Parameters:
//   SYNC_STAGES   : synchroniser depth, 2..4
//   STABLE_CYCLES : matching samples needed to accept a change, >= 2
//   GLITCH_W      : width of the saturating glitch counter
// Ports:
//   clk        : system clock
//   reset      : asynchronous active-high reset
//   raw_in     : asynchronous raw level
//   db_out     : registered debounced level
//   busy       : high while a candidate change is being qualified
//   glitch_cnt : saturating count of rejected candidate changes
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                raw_in,
    output logic                db_out,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int                   CNT_W      = cntWidth(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0]  GLITCH_MAX = '1;

    logic                sync_q;
    db_state_t           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                db_q, db_d;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;
    logic [GLITCH_W-1:0] glitchInc;

    sync_ff_chain #(
        .STAGES (SYNC_STAGES)
    ) uSync (
        .clk   (clk),
        .reset (reset),
        .d     (raw_in),
        .q     (sync_q)
    );

    // Saturating increment: once the counter is all-ones it stays there.
    assign glitchInc = (glitch_q == GLITCH_MAX) ? glitch_q : glitch_q + GLITCH_W'(1);

    // State, counter, debounced level and glitch count all move together.
    // Reset drops any qualification in progress without scoring it as a glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= STABLE_LO;
            cnt_q    <= '0;
            db_q     <= 1'b0;
            glitch_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            db_q     <= db_d;
            glitch_q <= glitch_d;
        end
    end

    // Qualifier FSM. Entering a CHK state already counts the first differing
    // sample, so the counter hits STABLE_CYCLES-1 on the last required sample
    // and never has to hold STABLE_CYCLES itself.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        db_d     = db_q;
        glitch_d = glitch_q;
        case (state_q)
            STABLE_LO: begin
                if (sync_q) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_HI: begin
                if (!sync_q) begin
                    state_d  = STABLE_LO;
                    cnt_d    = '0;
                    glitch_d = glitchInc;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    db_d    = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE_HI: begin
                if (!sync_q) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_LO: begin
                if (sync_q) begin
                    state_d  = STABLE_HI;
                    cnt_d    = '0;
                    glitch_d = glitchInc;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    db_d    = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
                db_d    = 1'b0;
            end
        endcase
    end

    assign busy       = (state_q == CHK_HI) || (state_q == CHK_LO);
    assign db_out     = db_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync
// Self-checking bench for debounce_sync with SYNC_STAGES=2, STABLE_CYCLES=4,
// GLITCH_W=8 (six-edge latency). A behavioural model tracks the delayed sample
// stream and the length of the current run that disagrees with the output.
module tb_debounce_sync;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int GW     = 8;
    localparam int LAT    = SYNC + STABLE;

    logic          clk = 1'b0;
    logic          reset;
    logic          raw_in;
    logic          db_out;
    logic          busy;
    logic [GW-1:0] glitch_cnt;

    int total = 0;
    int bad   = 0;

    bit rawHist[$];
    bit mDb;
    int mRun;
    int mGlitch;

    always #5 clk = ~clk;

    debounce_sync #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .GLITCH_W      (GW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (raw_in),
        .db_out     (db_out),
        .busy       (busy),
        .glitch_cnt (glitch_cnt)
    );

    // Reference model: each edge consumes the raw level seen SYNC edges earlier.
    // The output flips once STABLE consecutive samples disagree with it; a
    // disagreeing run cut short by an agreeing sample is one glitch.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rawHist.delete();
            for (int i = 0; i < SYNC; i++) rawHist.push_back(1'b0);
            mDb     = 1'b0;
            mRun    = 0;
            mGlitch = 0;
        end else begin
            bit s;
            rawHist.push_back(raw_in);
            s = rawHist.pop_front();
            if (s != mDb) begin
                mRun++;
                if (mRun == STABLE) begin
                    mDb  = ~mDb;
                    mRun = 0;
                end
            end else begin
                if (mRun > 0 && mGlitch < (1 << GW) - 1) mGlitch++;
                mRun = 0;
            end
        end
    end

    // Bring the block back to a clean low state with raw_in low.
    task automatic applyReset();
        raw_in = 1'b0;
        reset  = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Outputs held clear during reset, then the full qualification of a high
    // raw_in that was already present at release.
    task automatic test_reset();
        raw_in = 1'b1;
        reset  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (db_out !== 1'b0 || busy !== 1'b0 || glitch_cnt !== '0) begin
                bad++;
                $display("[TB] FAIL reset_hold: db=%b busy=%b glitch=%0d, want 0/0/0", db_out, busy, glitch_cnt);
            end
        end
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            total++;
            if (busy !== 1'((e >= 3) && (e <= 5))) begin
                bad++;
                $display("[TB] FAIL reset_busy edge %0d: got %b want %b", e, busy, (e >= 3) && (e <= 5));
            end
            total++;
            if (db_out !== 1'(e >= LAT)) begin
                bad++;
                $display("[TB] FAIL reset_db edge %0d: got %b want %b", e, db_out, e >= LAT);
            end
        end
        total++;
        if (glitch_cnt !== '0) begin
            bad++;
            $display("[TB] FAIL reset_glitch: got %0d want 0", glitch_cnt);
        end
    endtask

    // Clean rise then clean fall, each exactly LAT edges after the first new sample.
    task automatic test_clean_rise_fall();
        applyReset();
        raw_in = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            total++;
            if (db_out !== 1'(e >= LAT) || db_out !== mDb) begin
                bad++;
                $display("[TB] FAIL rise edge %0d: got %b want %b (model %b)", e, db_out, e >= LAT, mDb);
            end
        end
        raw_in = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            total++;
            if (db_out !== 1'(e < LAT) || busy !== 1'(mRun > 0)) begin
                bad++;
                $display("[TB] FAIL fall edge %0d: db=%b want %b busy=%b want %b", e, db_out, e < LAT, busy, mRun > 0);
            end
        end
        total++;
        if (glitch_cnt !== '0) begin
            bad++;
            $display("[TB] FAIL clean_glitch: got %0d want 0", glitch_cnt);
        end
    endtask

    // A run one short of STABLE is a glitch; a run of exactly STABLE is accepted
    // and produces an output pulse exactly STABLE cycles wide.
    task automatic test_boundary_pulses();
        int highCycles;
        applyReset();
        raw_in = 1'b1;
        repeat (STABLE - 1) @(negedge clk);
        raw_in = 1'b0;
        highCycles = 0;
        repeat (12) begin
            @(negedge clk);
            if (db_out === 1'b1) highCycles++;
        end
        total++;
        if (highCycles !== 0 || glitch_cnt !== GW'(1)) begin
            bad++;
            $display("[TB] FAIL short_run: high cycles %0d glitch %0d, want 0 and 1", highCycles, glitch_cnt);
        end
        raw_in = 1'b1;
        repeat (STABLE) @(negedge clk);
        raw_in = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (db_out === 1'b1) highCycles++;
        end
        total++;
        if (highCycles !== STABLE) begin
            bad++;
            $display("[TB] FAIL exact_run_width: got %0d want %0d", highCycles, STABLE);
        end
        total++;
        if (glitch_cnt !== GW'(1) || glitch_cnt !== GW'(mGlitch)) begin
            bad++;
            $display("[TB] FAIL exact_run_glitch: got %0d want 1 (model %0d)", glitch_cnt, mGlitch);
        end
    endtask

    // Bouncy release from a high output: two aborted candidates, then one fall.
    task automatic test_bounce_release();
        logic [5:0] pattern;
        applyReset();
        raw_in = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (db_out !== 1'b1) begin
            bad++;
            $display("[TB] FAIL bounce_setup: db got %b want 1", db_out);
        end
        pattern = 6'b010010;
        for (int e = 1; e <= 18; e++) begin
            raw_in = (e <= 6) ? pattern[6-e] : 1'b0;
            @(negedge clk);
            total++;
            if (db_out !== 1'(e < 11) || db_out !== mDb) begin
                bad++;
                $display("[TB] FAIL bounce_db edge %0d: got %b want %b", e, db_out, e < 11);
            end
        end
        total++;
        if (glitch_cnt !== GW'(2)) begin
            bad++;
            $display("[TB] FAIL bounce_glitch: got %0d want 2", glitch_cnt);
        end
    endtask

    // 300 isolated one-cycle pulses: glitch counter saturates at all-ones.
    task automatic test_saturation();
        int highCycles;
        applyReset();
        highCycles = 0;
        for (int p = 1; p <= 300; p++) begin
            raw_in = 1'b1;
            @(negedge clk);
            if (db_out === 1'b1) highCycles++;
            raw_in = 1'b0;
            repeat (5) begin
                @(negedge clk);
                if (db_out === 1'b1) highCycles++;
            end
            if (p == 100) begin
                total++;
                if (glitch_cnt !== GW'(100)) begin
                    bad++;
                    $display("[TB] FAIL sat_mid: got %0d want 100", glitch_cnt);
                end
            end
        end
        total++;
        if (glitch_cnt !== 8'd255 || glitch_cnt !== GW'(mGlitch)) begin
            bad++;
            $display("[TB] FAIL sat_final: got %0d want 255 (model %0d)", glitch_cnt, mGlitch);
        end
        total++;
        if (highCycles !== 0) begin
            bad++;
            $display("[TB] FAIL sat_db: db high for %0d cycles, want 0", highCycles);
        end
    endtask

    // Reset in the middle of qualifying a rise aborts it immediately, and the
    // still-high input is qualified again from scratch after release.
    task automatic test_reset_mid();
        applyReset();
        raw_in = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_busy_before: got %b want 1", busy);
        end
        reset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || db_out !== 1'b0 || glitch_cnt !== '0) begin
            bad++;
            $display("[TB] FAIL mid_async: busy=%b db=%b glitch=%0d, want 0/0/0", busy, db_out, glitch_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            total++;
            if (db_out !== 1'(e >= LAT) || busy !== 1'((e >= 3) && (e <= 5))) begin
                bad++;
                $display("[TB] FAIL mid_requal edge %0d: db=%b want %b busy=%b want %b",
                         e, db_out, e >= LAT, busy, (e >= 3) && (e <= 5));
            end
        end
        total++;
        if (glitch_cnt !== '0) begin
            bad++;
            $display("[TB] FAIL mid_glitch: got %0d want 0", glitch_cnt);
        end
    endtask

    // Random runs of 1..7 cycles, every cycle compared against the model.
    task automatic test_random();
        int runLeft;
        applyReset();
        runLeft = 0;
        for (int c = 0; c < 600; c++) begin
            if (runLeft == 0) begin
                raw_in  = 1'($urandom_range(0, 1));
                runLeft = $urandom_range(1, 7);
            end
            runLeft--;
            @(negedge clk);
            total++;
            if (db_out !== mDb || busy !== 1'(mRun > 0) || glitch_cnt !== GW'(mGlitch)) begin
                bad++;
                $display("[TB] FAIL random cyc %0d: db=%b/%b busy=%b/%b glitch=%0d/%0d",
                         c, db_out, mDb, busy, mRun > 0, glitch_cnt, mGlitch);
            end
        end
    endtask

    initial begin
        raw_in = 1'b0;
        reset  = 1'b1;
        test_reset();
        test_clean_rise_fall();
        test_boundary_pulses();
        test_bounce_release();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
